// File: rtl/hz_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: controller states,
// register-index width and the register-match helper used by load-use detection.
package hz_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      MD_BUSY = 2'b01
   } hz_state_e;

   // True when an issue-stage source is actually read and names the given register.
   function automatic logic src_hit(input logic used,
                                    input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst);
      return used & (src == dst);
   endfunction

endpackage

// File: rtl/md_occ_counter.sv
// Mul/div occupancy counter: loads the remaining-cycle count at start and
// counts down to zero, never wrapping.
module md_occ_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencing: load-use bubbles, taken-branch squash, and
// ownership of the iterative multiply/divide unit with HI/LO interlock.
module hazard_stall_ctrl #(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_ex_hz_i,
   input  logic [4:0]       rt_ex_hz_i,
   input  logic [4:0]       rs_iss_hz_i,
   input  logic [4:0]       rt_iss_hz_i,
   input  logic             rs_used_iss_hz_i,
   input  logic             rt_used_iss_hz_i,
   input  logic             br_taken_ex_hz_i,
   input  logic             md_start_iss_hz_i,
   input  logic             md_rd_iss_hz_i,
   output logic             stall_fetch_hz_o,
   output logic             stall_iss_hz_o,
   output logic             flush_iss_hz_o,
   output logic             flush_ex_hz_o,
   output logic             md_start_hz_o,
   output logic             md_done_hz_o,
   output logic             md_busy_hz_o,
   output logic [CNT_W-1:0] md_cnt_hz_o
);

   import hz_pkg::*;

   localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

   if ((MD_CYCLES < 2) || ((MD_CYCLES - 1) >= (1 << CNT_W))) begin : g_bad_params
      $error("hazard_stall_ctrl: MD_CYCLES must be >= 2 and MD_CYCLES-1 must fit in CNT_W bits");
   end

   hz_state_e        state_q;
   hz_state_e        state_d;
   logic             luse;
   logic             br;
   logic             md_active;
   logic             interlock;
   logic             stall;
   logic             md_start;
   logic             md_done;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt;

   assign br = br_taken_ex_hz_i;

   assign luse = ld_ex_hz_i && (rt_ex_hz_i != REG_ZERO) &&
                 (src_hit(rs_used_iss_hz_i, rs_iss_hz_i, rt_ex_hz_i) ||
                  src_hit(rt_used_iss_hz_i, rt_iss_hz_i, rt_ex_hz_i));

   assign md_active = (state_q == MD_BUSY);

   // HI/LO consumers and a second mult/div wait out the busy unit, done cycle included.
   assign interlock = md_active && (md_rd_iss_hz_i || md_start_iss_hz_i);

   // A taken branch squashes the issue slot, so nothing there may stall or start.
   assign stall    = (luse || interlock) && !br;
   assign md_start = (state_q == IDLE) && md_start_iss_hz_i && !luse && !br;
   assign md_done  = md_active && cnt_zero;

   md_occ_counter #(
      .CNT_W(CNT_W)
   ) u_md_occ_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (md_start),
      .load_val (MD_LOAD),
      .dec      (md_active),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (md_start) begin
               state_d = MD_BUSY;
            end
         end
         MD_BUSY: begin
            if (cnt_zero) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are forced low while reset is held, even with live issue/EX inputs.
   assign stall_fetch_hz_o = rst_n && stall;
   assign stall_iss_hz_o   = rst_n && stall;
   assign flush_ex_hz_o    = rst_n && stall;
   assign flush_iss_hz_o   = rst_n && br;
   assign md_start_hz_o    = rst_n && md_start;
   assign md_done_hz_o     = rst_n && md_done;
   assign md_busy_hz_o     = rst_n && md_active;
   assign md_cnt_hz_o      = cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl with a 4-cycle mul/div unit.
module tb_hazard_stall_ctrl;

   localparam int MD_CYCLES = 4;
   localparam int CNT_W     = 6;

   // Output vector order: {stall_fetch, stall_iss, flush_iss, flush_ex, md_start, md_done, md_busy}
   localparam logic [6:0] IDLE_O  = 7'b0000000;
   localparam logic [6:0] STALL_O = 7'b1101000;
   localparam logic [6:0] BR_O    = 7'b0010000;
   localparam logic [6:0] START_O = 7'b0000100;
   localparam logic [6:0] BUSY_O  = 7'b0000001;
   localparam logic [6:0] DONE_O  = 7'b0000011;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ld_ex;
   logic [4:0]       rt_ex;
   logic [4:0]       rs_iss;
   logic [4:0]       rt_iss;
   logic             rs_used;
   logic             rt_used;
   logic             br_taken;
   logic             md_start_iss;
   logic             md_rd_iss;
   logic             stall_fetch;
   logic             stall_iss;
   logic             flush_iss;
   logic             flush_ex;
   logic             md_start;
   logic             md_done;
   logic             md_busy;
   logic [CNT_W-1:0] md_cnt;
   logic [6:0]       obs;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   assign obs = {stall_fetch, stall_iss, flush_iss, flush_ex, md_start, md_done, md_busy};

   hazard_stall_ctrl #(
      .MD_CYCLES(MD_CYCLES),
      .CNT_W    (CNT_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ld_ex_hz_i        (ld_ex),
      .rt_ex_hz_i        (rt_ex),
      .rs_iss_hz_i       (rs_iss),
      .rt_iss_hz_i       (rt_iss),
      .rs_used_iss_hz_i  (rs_used),
      .rt_used_iss_hz_i  (rt_used),
      .br_taken_ex_hz_i  (br_taken),
      .md_start_iss_hz_i (md_start_iss),
      .md_rd_iss_hz_i    (md_rd_iss),
      .stall_fetch_hz_o  (stall_fetch),
      .stall_iss_hz_o    (stall_iss),
      .flush_iss_hz_o    (flush_iss),
      .flush_ex_hz_o     (flush_ex),
      .md_start_hz_o     (md_start),
      .md_done_hz_o      (md_done),
      .md_busy_hz_o      (md_busy),
      .md_cnt_hz_o       (md_cnt)
   );

   task automatic clear_inputs();
      ld_ex = 1'b0; rt_ex = '0; rs_iss = '0; rt_iss = '0;
      rs_used = 1'b0; rt_used = 1'b0; br_taken = 1'b0;
      md_start_iss = 1'b0; md_rd_iss = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use();
      ld_ex = 1'b1; rt_ex = 5'd8; rs_iss = 5'd8; rs_used = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      set_load_use();
      md_start_iss = 1'b1;
      #12;
      total++;
      if (obs !== IDLE_O) $display("[TB] FAIL reset_outputs: got %b want %b", obs, IDLE_O);
      else passed++;
      total++;
      if (md_cnt !== '0) $display("[TB] FAIL reset_cnt: got %0d want 0", md_cnt);
      else passed++;
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_load_use();
      set_load_use();
      @(negedge clk);
      total++;
      if (obs !== STALL_O) $display("[TB] FAIL load_use_rs: got %b want %b", obs, STALL_O);
      else passed++;
      next_cycle();
      clear_inputs();
      rs_iss = 5'd8; rs_used = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== IDLE_O) $display("[TB] FAIL load_use_bubble: got %b want %b", obs, IDLE_O);
      else passed++;
      next_cycle();
      clear_inputs();
      ld_ex = 1'b1; rt_ex = 5'd17; rt_iss = 5'd17; rt_used = 1'b1; rs_iss = 5'd3; rs_used = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== STALL_O) $display("[TB] FAIL load_use_rt: got %b want %b", obs, STALL_O);
      else passed++;
      next_cycle();
      clear_inputs();
      ld_ex = 1'b1; rt_ex = 5'd8; rs_iss = 5'd9; rs_used = 1'b1; rt_iss = 5'd10; rt_used = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== IDLE_O) $display("[TB] FAIL load_no_match: got %b want %b", obs, IDLE_O);
      else passed++;
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_zero_reg();
      ld_ex = 1'b1; rt_ex = 5'd0; rs_iss = 5'd0; rs_used = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== IDLE_O) $display("[TB] FAIL zero_reg: got %b want %b", obs, IDLE_O);
      else passed++;
      next_cycle();
      clear_inputs();
      ld_ex = 1'b1; rt_ex = 5'd5; rt_iss = 5'd5; rt_used = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== IDLE_O) $display("[TB] FAIL rt_unused: got %b want %b", obs, IDLE_O);
      else passed++;
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_branch_priority();
      set_load_use();
      br_taken = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== BR_O) $display("[TB] FAIL branch_over_luse: got %b want %b", obs, BR_O);
      else passed++;
      next_cycle();
      clear_inputs();
      br_taken = 1'b1; md_start_iss = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== BR_O) $display("[TB] FAIL branch_blocks_start: got %b want %b", obs, BR_O);
      else passed++;
      next_cycle();
      clear_inputs();
      set_load_use();
      md_start_iss = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== STALL_O) $display("[TB] FAIL luse_blocks_start: got %b want %b", obs, STALL_O);
      else passed++;
      next_cycle();
      clear_inputs();
      @(negedge clk);
      total++;
      if (obs !== IDLE_O) $display("[TB] FAIL no_spurious_busy: got %b want %b", obs, IDLE_O);
      else passed++;
      next_cycle();
   endtask

   task automatic test_md_sequence();
      logic [6:0] exp_o [0:5];
      int         exp_c [0:5];
      exp_o = '{START_O, BUSY_O, BUSY_O, BUSY_O, DONE_O, IDLE_O};
      exp_c = '{0, 3, 2, 1, 0, 0};
      for (int k = 0; k < 6; k++) begin
         clear_inputs();
         if (k == 0) md_start_iss = 1'b1;
         @(negedge clk);
         total++;
         if (obs !== exp_o[k]) $display("[TB] FAIL md_seq_c%0d: got %b want %b", k, obs, exp_o[k]);
         else passed++;
         total++;
         if (md_cnt !== CNT_W'(exp_c[k])) $display("[TB] FAIL md_cnt_c%0d: got %0d want %0d", k, md_cnt, exp_c[k]);
         else passed++;
         next_cycle();
      end
   endtask

   task automatic test_interlock();
      logic [6:0] exp_o [0:5];
      int         exp_c [0:5];
      exp_o = '{START_O, BUSY_O, 7'b1101001, 7'b1101001, 7'b1101011, IDLE_O};
      exp_c = '{0, 3, 2, 1, 0, 0};
      for (int k = 0; k < 6; k++) begin
         clear_inputs();
         if (k == 0) md_start_iss = 1'b1;
         if (k >= 2) md_rd_iss = 1'b1;
         @(negedge clk);
         total++;
         if (obs !== exp_o[k]) $display("[TB] FAIL mflo_c%0d: got %b want %b", k, obs, exp_o[k]);
         else passed++;
         total++;
         if (md_cnt !== CNT_W'(exp_c[k])) $display("[TB] FAIL mflo_cnt_c%0d: got %0d want %0d", k, md_cnt, exp_c[k]);
         else passed++;
         next_cycle();
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp_o [0:10];
      int         exp_c [0:10];
      exp_o = '{START_O, BUSY_O, 7'b1101001, 7'b1101001, 7'b1101011, START_O,
                BUSY_O, BUSY_O, BUSY_O, DONE_O, IDLE_O};
      exp_c = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
      for (int k = 0; k < 11; k++) begin
         clear_inputs();
         if (k == 0 || (k >= 2 && k <= 5)) md_start_iss = 1'b1;
         @(negedge clk);
         total++;
         if (obs !== exp_o[k]) $display("[TB] FAIL b2b_c%0d: got %b want %b", k, obs, exp_o[k]);
         else passed++;
         total++;
         if (md_cnt !== CNT_W'(exp_c[k])) $display("[TB] FAIL b2b_cnt_c%0d: got %0d want %0d", k, md_cnt, exp_c[k]);
         else passed++;
         next_cycle();
      end
   endtask

   task automatic test_branch_while_busy();
      logic [6:0] exp_o [0:5];
      int         exp_c [0:5];
      exp_o = '{START_O, BUSY_O, 7'b0010001, 7'b1101001, DONE_O, IDLE_O};
      exp_c = '{0, 3, 2, 1, 0, 0};
      for (int k = 0; k < 6; k++) begin
         clear_inputs();
         if (k == 0) md_start_iss = 1'b1;
         if (k == 2) begin
            br_taken = 1'b1; md_rd_iss = 1'b1;
         end
         if (k == 3) begin
            md_rd_iss = 1'b1;
            set_load_use();
         end
         @(negedge clk);
         total++;
         if (obs !== exp_o[k]) $display("[TB] FAIL br_busy_c%0d: got %b want %b", k, obs, exp_o[k]);
         else passed++;
         total++;
         if (md_cnt !== CNT_W'(exp_c[k])) $display("[TB] FAIL br_busy_cnt_c%0d: got %0d want %0d", k, md_cnt, exp_c[k]);
         else passed++;
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_op();
      clear_inputs();
      md_start_iss = 1'b1;
      next_cycle();
      clear_inputs();
      next_cycle();
      md_rd_iss = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== 7'b1101001) $display("[TB] FAIL pre_reset_stall: got %b want %b", obs, 7'b1101001);
      else passed++;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (obs !== IDLE_O) $display("[TB] FAIL async_reset_outputs: got %b want %b", obs, IDLE_O);
      else passed++;
      total++;
      if (md_cnt !== '0) $display("[TB] FAIL async_reset_cnt: got %0d want 0", md_cnt);
      else passed++;
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      next_cycle();
      for (int k = 0; k < MD_CYCLES + 2; k++) begin
         @(negedge clk);
         total++;
         if (obs !== IDLE_O) $display("[TB] FAIL post_reset_c%0d: got %b want %b", k, obs, IDLE_O);
         else passed++;
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_reg();
      test_branch_priority();
      test_md_sequence();
      test_interlock();
      test_back_to_back();
      test_branch_while_busy();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Sequencing controller for the MIPS pipeline's stall and flush controls, which today are tied to zero. It detects load-use hazards, redirects on a taken branch, and owns the iterative multiply/divide unit (HI/LO). It tracks the mul/div occupancy counter and interlocks any HI/LO consumer until the unit completes. Sits beside the forwarding logic; drives fetch/issue stall, issue/EX flush, and the mul/div start/done strobes.

Parameters:
MD_CYCLES, 32, EX-side cycles a mult/div occupies the unit (>=2)
CNT_W, 6, width of occupancy counter (must hold MD_CYCLES-1)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_ex_hz_i  in  1  instruction in EX is a load (mem_to_reg)
rt_ex_hz_i  in  5  destination register of load in EX
rs_iss_hz_i  in  5  rs of instruction in issue
rt_iss_hz_i  in  5  rt of instruction in issue
rs_used_iss_hz_i  in  1  issue instruction reads rs
rt_used_iss_hz_i  in  1  issue instruction reads rt
br_taken_ex_hz_i  in  1  branch/jump in EX resolved taken
md_start_iss_hz_i  in  1  issue instruction is mult/multu/div/divu
md_rd_iss_hz_i  in  1  issue instruction is mfhi/mflo/mthi/mtlo
stall_fetch_hz_o  out  1  hold PC/fetch register
stall_iss_hz_o  out  1  hold issue register
flush_iss_hz_o  out  1  squash issue register (wrong path)
flush_ex_hz_o  out  1  insert bubble into EX
md_start_hz_o  out  1  one-cycle start pulse to mul/div datapath
md_done_hz_o  out  1  one-cycle pulse: HI/LO written at this edge
md_busy_hz_o  out  1  unit occupied
md_cnt_hz_o  out  CNT_W  remaining cycles (debug/verif)

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0; outputs all 0. Leaving reset mid-operation is clean: no done pulse, no stall.
- States: IDLE, MD_BUSY. The 2-bit state register is encoded in the package.
- Load-use (combinational, any state): luse = ld_ex & rt_ex!=0 & ((rs_used & rs_iss==rt_ex) | (rt_used & rt_iss==rt_ex)).
- Load-use asserts stall_fetch, stall_iss, flush_ex for that cycle. Exactly one bubble results, because the next cycle EX holds the bubble.
- Branch: br_taken_ex -> flush_iss=1. It overrides every stall that cycle: stall_fetch=0, stall_iss=0, flush_ex=0.
- A flushed issue instruction can neither start mul/div nor raise an interlock.
- MD issue, state IDLE: md_start_iss & !luse & !br_taken -> md_start_hz_o=1 this cycle.
  - Next edge: state MD_BUSY, counter=MD_CYCLES-1, md_busy=1.
- MD_BUSY: counter decrements each cycle.
  - At counter==0: md_done=1 for that cycle; next edge state=IDLE, busy=0.
  - Total busy = MD_CYCLES cycles, counted from the cycle after md_start.
- Interlock in MD_BUSY, including the done cycle: issue holds md_rd_iss or md_start_iss, and br_taken is low -> stall_fetch, stall_iss, flush_ex.
  - Stall releases the cycle after md_done. The consumer then advances, and a new mult/div starts from IDLE that cycle.
- Simultaneous luse and interlock: identical outputs (OR), no double bubble.
- Taken branch while MD_BUSY: the unit continues; it is older than the branch and is never cancelled.
- Counter never wraps; decrement is gated at 0. Width check: MD_CYCLES-1 < 2^CNT_W.
- md_start_hz_o is never asserted in MD_BUSY.

Decomposition:
- Shared package hz_pkg: state encoding (IDLE, MD_BUSY), REG_W=5, register-zero constant.
- One natural sub-module: md_occ_counter (load/decrement/zero-detect, CNT_W param), instantiated once.
- Load-use and branch logic stay in the top.

Test Plan:
- Load-use: ld_ex=1, rt_ex=8, rs_iss=8, rs_used=1 -> one cycle of stall_fetch=stall_iss=flush_ex=1; next cycle all 0.
- $zero: ld_ex=1, rt_ex=0, rs_iss=0 -> no stall. Also rt_used=0 with rt_iss=rt_ex=5 -> no stall.
- Branch priority: luse and br_taken_ex in the same cycle -> flush_iss=1; stall_fetch, stall_iss, flush_ex=0.
- MD sequence (MD_CYCLES=4): md_start_iss in IDLE -> md_start pulse cycle 0; busy cycles 1-4; cnt 3,2,1,0; md_done at cycle 4; busy=0 at cycle 5.
- Interlock: mflo in issue at cycle 2 of the above -> stall/flush_ex held cycles 2-4, released cycle 5. A back-to-back mult held the same way starts at cycle 5.
- Reset mid-op: rst_n low at cycle 2 of MD sequence -> busy, cnt, stalls go 0 asynchronously; no md_done after release.
